jamma_joy_mux: RTL and testbench

Time-multiplexed JAMMA joystick front end for the arcade tops. It drives the external joystick select line and samples the shared 8-bit JAMMA joystick bus once per phase. Both player vectors are synchronized and debounced, and player 1 is merged with the keyboard joystick. It replaces the free-running per-clock `joy_split` toggle, which samples the bus with no settling time, and it feeds the core's `I_JOYSTICK_A/B` and `I_PLAYER` inputs directly.

---
 rtl/jamma_pkg.sv | 19 +
 rtl/jamma_joy_mux_if.sv | 30 +++
 rtl/jamma_debounce.sv | 37 +++
 rtl/jamma_joy_mux.sv | 98 +++++++++
 tb/tb_jamma_joy_mux.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA joystick front end.
// Holds the scan FSM encoding, idle bus value and parameter limits.
package jamma_pkg;

   typedef enum logic [1:0] {
      P1_SETTLE = 2'd0,
      P1_SAMPLE = 2'd1,
      P2_SETTLE = 2'd2,
      P2_SAMPLE = 2'd3
   } jmux_state_t;

   localparam logic [7:0] JOY_IDLE = 8'hFF;

   localparam int SETTLE_MIN = 3;
   localparam int SETTLE_MAX = 255;
   localparam int DB_MIN     = 1;
   localparam int DB_MAX     = 15;

endpackage

// File: rtl/jamma_joy_mux_if.sv
// Joystick bundle between the JAMMA edge, keyboard logic and the core.
// master = the mux itself, slave = whatever drives/consumes it.
interface jamma_joy_mux_if;

   logic [7:0] jjoy;
   logic [5:0] kbd_joy;
   logic       jselect;
   logic [7:0] joystick1;
   logic [7:0] joystick2;
   logic       scan_done;

   modport master (
      input  jjoy,
      input  kbd_joy,
      output jselect,
      output joystick1,
      output joystick2,
      output scan_done
   );

   modport slave (
      output jjoy,
      output kbd_joy,
      input  jselect,
      input  joystick1,
      input  joystick2,
      input  scan_done
   );

endinterface

// File: rtl/jamma_debounce.sv
// 8-bit strobe-driven debouncer; a bit flips only after DB_SAMPLES
// consecutive disagreeing samples, any agreeing sample clears its count.
module jamma_debounce
   import jamma_pkg::*;
#(
   parameter int DB_SAMPLES = 4
) (
   input  logic       pclk,
   input  logic       reset,
   input  logic       strobe,
   input  logic [7:0] din,
   output logic [7:0] dout
);

   localparam logic [3:0] DB_LAST = 4'(DB_SAMPLES - 1);

   logic [3:0] cnt [8];

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         dout <= JOY_IDLE;
         for (int i = 0; i < 8; i++) cnt[i] <= '0;
      end else if (strobe) begin
         for (int i = 0; i < 8; i++) begin
            if (din[i] == dout[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               dout[i] <= din[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/jamma_joy_mux.sv
// Time-multiplexed JAMMA joystick scanner: drives jselect, samples the
// shared bus after a settle window, debounces both players, merges keyboard.
module jamma_joy_mux
   import jamma_pkg::*;
#(
   parameter int SETTLE     = 4,
   parameter int DB_SAMPLES = 4
) (
   input logic             pclk,
   input logic             reset,
   jamma_joy_mux_if.master bus
);

   if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
      $error("jamma_joy_mux: SETTLE out of range");
   end
   if (DB_SAMPLES < DB_MIN || DB_SAMPLES > DB_MAX) begin : g_bad_db
      $error("jamma_joy_mux: DB_SAMPLES out of range");
   end

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   logic [7:0]  sync1;
   logic [7:0]  jjoy_s;
   jmux_state_t state;
   jmux_state_t state_nxt;
   logic [7:0]  settle_cnt;
   logic [7:0]  deb1;
   logic [7:0]  deb2;
   logic        stb1;
   logic        stb2;

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         sync1  <= JOY_IDLE;
         jjoy_s <= JOY_IDLE;
      end else begin
         sync1  <= bus.jjoy;
         jjoy_s <= sync1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         P1_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = P1_SAMPLE;
         P1_SAMPLE: state_nxt = P2_SETTLE;
         P2_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = P2_SAMPLE;
         P2_SAMPLE: state_nxt = P1_SETTLE;
         default:   state_nxt = P1_SETTLE;
      endcase
   end

   // jselect decodes the next state so it is registered yet aligned with state
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state         <= P1_SETTLE;
         settle_cnt    <= '0;
         bus.jselect   <= 1'b0;
         bus.scan_done <= 1'b0;
      end else begin
         state         <= state_nxt;
         settle_cnt    <= (state_nxt != state) ? 8'd0 : settle_cnt + 8'd1;
         bus.jselect   <= (state_nxt == P2_SETTLE) || (state_nxt == P2_SAMPLE);
         bus.scan_done <= (state == P2_SAMPLE);
      end
   end

   assign stb1 = (state == P1_SAMPLE);
   assign stb2 = (state == P2_SAMPLE);

   jamma_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_deb1 (
      .pclk   (pclk),
      .reset  (reset),
      .strobe (stb1),
      .din    (jjoy_s),
      .dout   (deb1)
   );

   jamma_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_deb2 (
      .pclk   (pclk),
      .reset  (reset),
      .strobe (stb2),
      .din    (jjoy_s),
      .dout   (deb2)
   );

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         bus.joystick1 <= JOY_IDLE;
         bus.joystick2 <= JOY_IDLE;
      end else begin
         bus.joystick1 <= deb1 & {2'b11, bus.kbd_joy};
         bus.joystick2 <= deb2;
      end
   end

endmodule

// File: tb/tb_jamma_joy_mux.sv
// Directed bench for jamma_joy_mux: default and fast-parameter instances,
// external mux modelled by steering jjoy from jselect.
module tb_jamma_joy_mux;

   logic       pclk = 1'b0;
   logic       reset;
   logic       reset_b;
   logic [7:0] p1v;
   logic [7:0] p2v;
   logic [7:0] p1b;
   logic [7:0] p2b;
   int         errors = 0;
   int         checks = 0;

   jamma_joy_mux_if ifa ();
   jamma_joy_mux_if ifb ();

   assign ifa.jjoy = ifa.jselect ? p2v : p1v;
   assign ifb.jjoy = ifb.jselect ? p2b : p1b;

   always #5 pclk = ~pclk;

   jamma_joy_mux #(.SETTLE(4), .DB_SAMPLES(4)) u_dut (
      .pclk  (pclk),
      .reset (reset),
      .bus   (ifa)
   );

   jamma_joy_mux #(.SETTLE(3), .DB_SAMPLES(1)) u_fast (
      .pclk  (pclk),
      .reset (reset_b),
      .bus   (ifb)
   );

   task automatic step();
      @(negedge pclk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sync_scan();
      int n;
      n = 0;
      step();
      while (ifa.scan_done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("scan_wait", {7'd0, ifa.scan_done}, 8'd1);
   endtask

   logic [7:0] bseq [7];

   initial begin
      bseq = '{8'h7F, 8'hFF, 8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'hFF};
      reset   = 1'b1;
      reset_b = 1'b1;
      p1v = 8'h00;
      p2v = 8'h00;
      p1b = 8'hFE;
      p2b = 8'hFF;
      ifa.kbd_joy = 6'h3F;
      ifb.kbd_joy = 6'h3F;

      for (int i = 0; i < 5; i++) begin
         step();
         chk("rst_j1", ifa.joystick1, 8'hFF);
         chk("rst_j2", ifa.joystick2, 8'hFF);
         chk("rst_jsel", {7'd0, ifa.jselect}, 8'd0);
         chk("rst_done", {7'd0, ifa.scan_done}, 8'd0);
      end

      p1v = 8'hFF;
      p2v = 8'hFF;
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         chk("jsel_cyc", {7'd0, ifa.jselect},
             {7'd0, (c >= 5 && c <= 9)});
         chk("done_cyc", {7'd0, ifa.scan_done}, {7'd0, (c == 10)});
         step();
      end

      sync_scan();
      p1v = 8'hFE;
      repeat (3) sync_scan();
      chk("p1_3strobes", ifa.joystick1, 8'hFF);
      repeat (5) step();
      chk("p1_early", ifa.joystick1, 8'hFF);
      step();
      chk("p1_press", ifa.joystick1, 8'hFE);
      chk("p2_quiet", ifa.joystick2, 8'hFF);

      for (int i = 0; i < 7; i++) begin
         sync_scan();
         p2v = bseq[i];
         step();
         chk("p2_bounce", ifa.joystick2, 8'hFF);
      end
      sync_scan();
      step();
      chk("p2_bounce_end", ifa.joystick2, 8'hFF);

      sync_scan();
      p2v = 8'h7F;
      repeat (4) sync_scan();
      chk("p2_pre", ifa.joystick2, 8'hFF);
      step();
      chk("p2_press", ifa.joystick2, 8'h7F);
      chk("p1_held", ifa.joystick1, 8'hFE);

      sync_scan();
      p1v = 8'hFF;
      repeat (4) sync_scan();
      step();
      chk("p1_release", ifa.joystick1, 8'hFF);
      ifa.kbd_joy = 6'b111101;
      chk("kbd_before", ifa.joystick1, 8'hFF);
      step();
      chk("kbd_merge", ifa.joystick1, 8'hFD);
      chk("kbd_p2", ifa.joystick2, 8'h7F);
      ifa.kbd_joy = 6'h3F;
      step();
      chk("kbd_clear", ifa.joystick1, 8'hFF);

      sync_scan();
      p1v = 8'hFE;
      repeat (4) sync_scan();
      step();
      chk("p1_again", ifa.joystick1, 8'hFE);
      repeat (5) step();
      chk("pre_rst_jsel", {7'd0, ifa.jselect}, 8'd1);
      reset = 1'b1;
      #1;
      chk("mrst_j1", ifa.joystick1, 8'hFF);
      chk("mrst_j2", ifa.joystick2, 8'hFF);
      chk("mrst_jsel", {7'd0, ifa.jselect}, 8'd0);
      chk("mrst_done", {7'd0, ifa.scan_done}, 8'd0);
      step();
      step();
      chk("mrst_hold", ifa.joystick1, 8'hFF);
      reset = 1'b0;
      for (int c = 0; c < 37; c++) begin
         if (c == 4) chk("mrst_p1samp", {7'd0, ifa.jselect}, 8'd0);
         if (c == 5) chk("mrst_p2set", {7'd0, ifa.jselect}, 8'd1);
         if (c == 35) chk("mrst_early", ifa.joystick1, 8'hFF);
         if (c == 36) chk("mrst_reacq", ifa.joystick1, 8'hFE);
         step();
      end

      step();
      reset_b = 1'b0;
      for (int c = 0; c < 17; c++) begin
         if (c == 3) chk("fast_jsel3", {7'd0, ifb.jselect}, 8'd0);
         if (c == 4) chk("fast_jsel4", {7'd0, ifb.jselect}, 8'd1);
         if (c == 4) chk("fast_early", ifb.joystick1, 8'hFF);
         if (c == 5) chk("fast_press", ifb.joystick1, 8'hFE);
         if (c == 5) chk("fast_p2", ifb.joystick2, 8'hFF);
         if (c == 7) chk("fast_done7", {7'd0, ifb.scan_done}, 8'd0);
         if (c == 8) chk("fast_done8", {7'd0, ifb.scan_done}, 8'd1);
         if (c == 9) chk("fast_done9", {7'd0, ifb.scan_done}, 8'd0);
         if (c == 16) chk("fast_done16", {7'd0, ifb.scan_done}, 8'd1);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
